// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB sequencer: UART register byte
// addresses, the sequencer state encoding and the configuration write order.
package uart_apb_pkg;

   localparam logic [31:0] ADDR_MDR = 32'h00;
   localparam logic [31:0] ADDR_DLL = 32'h04;
   localparam logic [31:0] ADDR_DLH = 32'h08;
   localparam logic [31:0] ADDR_LCR = 32'h0C;
   localparam logic [31:0] ADDR_IER = 32'h10;
   localparam logic [31:0] ADDR_FSR = 32'h14;
   localparam logic [31:0] ADDR_TBR = 32'h18;
   localparam logic [31:0] ADDR_RBR = 32'h1C;

   // Index of the final configuration write (IER).
   localparam logic [2:0] CFG_LAST = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG_SETUP,
      ST_CFG_ACCESS,
      ST_TX_SETUP,
      ST_TX_ACCESS,
      ST_RX_SETUP,
      ST_RX_ACCESS
   } state_t;

   // Configuration order: LCR, DLL, DLH, MDR, IER.
   function automatic logic [31:0] cfg_addr(input logic [2:0] idx);
      case (idx)
         3'd0:    cfg_addr = ADDR_LCR;
         3'd1:    cfg_addr = ADDR_DLL;
         3'd2:    cfg_addr = ADDR_DLH;
         3'd3:    cfg_addr = ADDR_MDR;
         default: cfg_addr = ADDR_IER;
      endcase
   endfunction

endpackage

// File: rtl/apb_xfer_engine.sv
// Single-transfer APB master phase sequencer.
// A start pulse latches address/direction/data and issues SETUP on the next
// cycle, then ACCESS until PREADY or until the ACCESS timeout expires.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start, wr, addr, wdata transfer request (sampled when start=1)
//   pready, pslverr        APB completion / error from the slave
//   psel, penable, pwrite, paddr, pwdata   APB master outputs
//   done                   completion cycle (PREADY or timeout), combinational
//   err                    completion with PSLVERR, or timeout, combinational
module apb_xfer_engine #(
   parameter int PREADY_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [7:0]  wdata,
   input  logic        pready,
   input  logic        pslverr,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   output logic        done,
   output logic        err
);

   localparam int CW = $clog2(PREADY_TIMEOUT);
   localparam logic [CW-1:0] CNT_LOAD = CW'(PREADY_TIMEOUT - 1);

   logic [CW-1:0] cnt;
   logic          access;
   logic          tc;

   assign access = psel & penable;
   assign tc     = (cnt == '0);
   assign done   = access & (pready | tc);
   assign err    = access & (pready ? pslverr : tc);

   // start wins over completion so a new SETUP can follow a finishing ACCESS
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psel    <= 1'b0;
         penable <= 1'b0;
         pwrite  <= 1'b0;
         paddr   <= '0;
         pwdata  <= '0;
         cnt     <= '0;
      end else if (start) begin
         psel    <= 1'b1;
         penable <= 1'b0;
         pwrite  <= wr;
         paddr   <= addr;
         pwdata  <= {24'd0, wdata};
      end else if (psel && !penable) begin
         penable <= 1'b1;
         cnt     <= CNT_LOAD;
      end else if (done) begin
         psel    <= 1'b0;
         penable <= 1'b0;
      end else if (access) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/uart_apb_sequencer.sv
// APB master for the UART: runs the 5-write configuration sequence, then
// moves bytes from the TX stream to TBR and from RBR to the RX stream,
// round-robin arbitrating TX and RX over one APB port.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   cfg_start, cfg_lcr..cfg_ier         config request and register values
//   cfg_busy, cfg_done, configured      config status
//   tx_data/tx_valid/tx_ready           TX byte stream in
//   rx_data/rx_valid/rx_ready           RX byte stream out
//   tx_fifo_full, rx_fifo_empty         UART FIFO sideband
//   PSEL..PSLVERR                       APB master port
//   err, err_clr                        sticky error flag and its clear
//
// state         | meaning
// IDLE          | arbitrate cfg_start / TX / RX
// CFG_SETUP     | config write, APB SETUP phase
// CFG_ACCESS    | config write, APB ACCESS phase
// TX_SETUP      | TBR write, APB SETUP phase
// TX_ACCESS     | TBR write, APB ACCESS phase
// RX_SETUP      | RBR read, APB SETUP phase
// RX_ACCESS     | RBR read, APB ACCESS phase
module uart_apb_sequencer
   import uart_apb_pkg::*;
#(
   parameter int PREADY_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_start,
   input  logic [7:0]  cfg_lcr,
   input  logic [7:0]  cfg_dll,
   input  logic [7:0]  cfg_dlh,
   input  logic [7:0]  cfg_mdr,
   input  logic [7:0]  cfg_ier,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        configured,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   input  logic        tx_fifo_full,
   input  logic        rx_fifo_empty,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   input  logic        PREADY,
   input  logic        PSLVERR,
   input  logic [31:0] PRDATA,
   output logic        err,
   input  logic        err_clr
);

   state_t      state, state_nx;
   logic [2:0]  cfg_idx;
   logic [2:0]  cfg_sel;
   logic        rr_tx;
   logic        tx_elig, rx_elig;
   logic        cfg_go, tx_go, rx_go;
   logic        cfg_next, cfg_fin, rx_done;
   logic        eng_start, eng_wr, eng_done, eng_err;
   logic [31:0] eng_addr;
   logic [7:0]  eng_wdata, cfg_val;
   logic        unused_prdata;

   // only the byte lane carries RBR data
   assign unused_prdata = ^PRDATA[31:8];

   assign tx_elig = configured & tx_valid & ~tx_fifo_full;
   assign rx_elig = configured & ~rx_fifo_empty & ~rx_valid;

   // rr_tx = 1 means TX is preferred when both are eligible
   assign cfg_go = (state == ST_IDLE) & cfg_start;
   assign tx_go  = (state == ST_IDLE) & ~cfg_start & tx_elig & (~rx_elig | rr_tx);
   assign rx_go  = (state == ST_IDLE) & ~cfg_start & rx_elig & (~tx_elig | ~rr_tx);

   assign cfg_next = (state == ST_CFG_ACCESS) & eng_done & ~eng_err & (cfg_idx != CFG_LAST);
   assign cfg_fin  = (state == ST_CFG_ACCESS) & eng_done & ~eng_err & (cfg_idx == CFG_LAST);
   assign rx_done  = (state == ST_RX_ACCESS) & eng_done & ~eng_err;
   assign cfg_sel  = cfg_go ? 3'd0 : cfg_idx + 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (cfg_go)     state_nx = ST_CFG_SETUP;
            else if (tx_go) state_nx = ST_TX_SETUP;
            else if (rx_go) state_nx = ST_RX_SETUP;
         end
         ST_CFG_SETUP:  state_nx = ST_CFG_ACCESS;
         ST_CFG_ACCESS: if (eng_done) state_nx = cfg_next ? ST_CFG_SETUP : ST_IDLE;
         ST_TX_SETUP:   state_nx = ST_TX_ACCESS;
         ST_TX_ACCESS:  if (eng_done) state_nx = ST_IDLE;
         ST_RX_SETUP:   state_nx = ST_RX_ACCESS;
         ST_RX_ACCESS:  if (eng_done) state_nx = ST_IDLE;
         default:       state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      cfg_busy  = (state == ST_CFG_SETUP) | (state == ST_CFG_ACCESS);
      tx_ready  = tx_go;
      eng_start = cfg_go | cfg_next | tx_go | rx_go;
      eng_wr    = ~rx_go;
      case (cfg_sel)
         3'd0:    cfg_val = cfg_lcr;
         3'd1:    cfg_val = cfg_dll;
         3'd2:    cfg_val = cfg_dlh;
         3'd3:    cfg_val = cfg_mdr;
         default: cfg_val = cfg_ier;
      endcase
      if (tx_go) begin
         eng_addr  = ADDR_TBR;
         eng_wdata = tx_data;
      end else if (rx_go) begin
         eng_addr  = ADDR_RBR;
         eng_wdata = 8'd0;
      end else begin
         eng_addr  = cfg_addr(cfg_sel);
         eng_wdata = cfg_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_idx    <= 3'd0;
         rr_tx      <= 1'b1;
         configured <= 1'b0;
         cfg_done   <= 1'b0;
         rx_data    <= 8'd0;
         rx_valid   <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (cfg_go)        cfg_idx <= 3'd0;
         else if (cfg_next) cfg_idx <= cfg_idx + 3'd1;

         if (tx_go)      rr_tx <= 1'b0;
         else if (rx_go) rr_tx <= 1'b1;

         if (cfg_go)       configured <= 1'b0;
         else if (cfg_fin) configured <= 1'b1;
         cfg_done <= cfg_fin;

         if (rx_done) begin
            rx_data  <= PRDATA[7:0];
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         if (err_clr)      err <= 1'b0;
         else if (eng_err) err <= 1'b1;
      end
   end

   apb_xfer_engine #(.PREADY_TIMEOUT(PREADY_TIMEOUT)) u_xfer (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (eng_start),
      .wr      (eng_wr),
      .addr    (eng_addr),
      .wdata   (eng_wdata),
      .pready  (PREADY),
      .pslverr (PSLVERR),
      .psel    (PSEL),
      .penable (PENABLE),
      .pwrite  (PWRITE),
      .paddr   (PADDR),
      .pwdata  (PWDATA),
      .done    (eng_done),
      .err     (eng_err)
   );

endmodule

// File: tb/tb_uart_apb_sequencer.sv
module tb_uart_apb_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_start;
   logic [7:0]  cfg_lcr, cfg_dll, cfg_dlh, cfg_mdr, cfg_ier;
   logic        cfg_busy, cfg_done, configured;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_ready;
   logic        tx_fifo_full, rx_fifo_empty;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PREADY, PSLVERR;
   logic        err, err_clr;
   logic        slverr_on_dlh;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int n;
   int base;
   int dsnap;

   logic [31:0] log_addr[$];
   logic        log_wr[$];
   logic [31:0] log_data[$];

   logic [31:0] exp_addr[5];
   logic [31:0] exp_data[5];

   always #5 clk = ~clk;

   // slave answers DLH writes with an error when armed
   assign PSLVERR = slverr_on_dlh & PSEL & PENABLE & (PADDR == 32'h08);

   uart_apb_sequencer #(.PREADY_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
      .cfg_lcr(cfg_lcr), .cfg_dll(cfg_dll), .cfg_dlh(cfg_dlh), .cfg_mdr(cfg_mdr), .cfg_ier(cfg_ier),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .configured(configured),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_fifo_full(tx_fifo_full), .rx_fifo_empty(rx_fifo_empty),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
      .err(err), .err_clr(err_clr)
   );

   // completed APB transfers, in order
   always @(posedge clk) begin
      if (rst_n) begin
         if (PSEL && PENABLE && PREADY) begin
            log_addr.push_back(PADDR);
            log_wr.push_back(PWRITE);
            log_data.push_back(PWDATA);
         end
         if (cfg_done) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_config();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      repeat (12) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_addr = '{32'h0C, 32'h04, 32'h08, 32'h00, 32'h10};
      exp_data = '{32'h1B, 32'h36, 32'h00, 32'h01, 32'h0F};
      rst_n = 1'b0; cfg_start = 1'b0; err_clr = 1'b0;
      cfg_lcr = 8'h1B; cfg_dll = 8'h36; cfg_dlh = 8'h00; cfg_mdr = 8'h01; cfg_ier = 8'h0F;
      tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
      tx_fifo_full = 1'b0; rx_fifo_empty = 1'b1;
      PREADY = 1'b1; PRDATA = 32'h0; slverr_on_dlh = 1'b0;

      repeat (2) @(posedge clk);
      #2;
      check("rst_psel", PSEL, 0);
      check("rst_penable", PENABLE, 0);
      check("rst_paddr", PADDR, 0);
      check("rst_pwdata", PWDATA, 0);
      check("rst_cfg_busy", cfg_busy, 0);
      check("rst_configured", configured, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_err", err, 0);
      rst_n = 1'b1;
      tick();

      // configuration sequence
      base = log_addr.size();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      check("cfg_busy", cfg_busy, 1);
      check("cfg_first_setup_psel", PSEL, 1);
      check("cfg_first_setup_penable", PENABLE, 0);
      check("cfg_first_paddr", PADDR, 32'h0C);
      check("cfg_first_pwrite", PWRITE, 1);
      n = 0;
      while (!cfg_done && n < 40) begin
         tick();
         n++;
      end
      check("cfg_done_latency", n, 10);
      check("cfg_configured", configured, 1);
      check("cfg_busy_end", cfg_busy, 0);
      check("cfg_write_count", log_addr.size() - base, 5);
      for (int i = 0; i < 5; i++) begin
         if (base + i < log_addr.size()) begin
            check("cfg_addr", log_addr[base+i], exp_addr[i]);
            check("cfg_data", log_data[base+i], exp_data[i]);
            check("cfg_wr", log_wr[base+i], 1);
         end
      end
      tick();
      check("cfg_done_pulse", cfg_done, 0);

      // single TX byte
      tx_data = 8'hA5; tx_valid = 1'b1;
      #1;
      check("tx_ready_grant", tx_ready, 1);
      tick();
      tx_valid = 1'b0;
      check("tx_setup_psel", PSEL, 1);
      check("tx_setup_penable", PENABLE, 0);
      check("tx_paddr", PADDR, 32'h18);
      check("tx_pwdata", PWDATA, 32'hA5);
      check("tx_pwrite", PWRITE, 1);
      tick();
      check("tx_access_penable", PENABLE, 1);
      tick();
      check("tx_done_psel", PSEL, 0);

      // TX blocked by full FIFO
      base = log_addr.size();
      tx_fifo_full = 1'b1; tx_valid = 1'b1;
      #1;
      check("tx_full_ready", tx_ready, 0);
      repeat (4) tick();
      check("tx_full_psel", PSEL, 0);
      check("tx_full_no_xfer", log_addr.size() - base, 0);
      tx_valid = 1'b0; tx_fifo_full = 1'b0;

      // single RX byte, held without rx_ready
      base = log_addr.size();
      PRDATA = 32'hFFFF_FF3C; rx_fifo_empty = 1'b0; rx_ready = 1'b0;
      n = 0;
      while (!rx_valid && n < 20) begin
         tick();
         n++;
      end
      check("rx_valid", rx_valid, 1);
      check("rx_data", rx_data, 8'h3C);
      repeat (5) tick();
      check("rx_valid_held", rx_valid, 1);
      check("rx_single_read", log_addr.size() - base, 1);
      if (log_addr.size() > base) begin
         check("rx_paddr", log_addr[base], 32'h1C);
         check("rx_pwrite", log_wr[base], 0);
      end
      rx_fifo_empty = 1'b1; rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check("rx_consumed", rx_valid, 0);

      // both requesters eligible: grants alternate starting with TX
      base = log_addr.size();
      tx_data = 8'h5A; tx_valid = 1'b1; rx_fifo_empty = 1'b0; rx_ready = 1'b1;
      PRDATA = 32'h77;
      repeat (14) tick();
      tx_valid = 1'b0; rx_fifo_empty = 1'b1;
      repeat (5) tick();
      rx_ready = 1'b0;
      check("arb_count", (log_addr.size() - base) >= 4, 1);
      if (log_addr.size() >= base + 4) begin
         check("arb_0_tx", log_addr[base], 32'h18);
         check("arb_1_rx", log_addr[base+1], 32'h1C);
         check("arb_2_tx", log_addr[base+2], 32'h18);
         check("arb_3_rx", log_addr[base+3], 32'h1C);
      end

      // PSLVERR on DLH aborts configuration
      base = log_addr.size();
      dsnap = done_cnt;
      slverr_on_dlh = 1'b1;
      run_config();
      slverr_on_dlh = 1'b0;
      check("slverr_writes", log_addr.size() - base, 3);
      if (log_addr.size() >= base + 3) check("slverr_last_addr", log_addr[base+2], 32'h08);
      check("slverr_err", err, 1);
      check("slverr_no_done", done_cnt - dsnap, 0);
      check("slverr_configured", configured, 0);
      check("slverr_busy", cfg_busy, 0);
      tx_valid = 1'b1;
      #1;
      check("slverr_tx_blocked", tx_ready, 0);
      tx_valid = 1'b0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("err_clr", err, 0);

      // reconfigure, then PREADY timeout on a TX write
      run_config();
      check("reconfig", configured, 1);
      PREADY = 1'b0;
      tx_data = 8'hC3; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tick();
      n = 0;
      while (PSEL && PENABLE && n < 40) begin
         n++;
         tick();
      end
      check("timeout_access_cycles", n, 16);
      check("timeout_psel", PSEL, 0);
      check("timeout_err", err, 1);
      PREADY = 1'b1;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("timeout_err_clr", err, 0);

      // reset in TX_ACCESS
      PREADY = 1'b0;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tick();
      check("rst_mid_access", PENABLE, 1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_psel", PSEL, 0);
      check("rst_mid_penable", PENABLE, 0);
      check("rst_mid_configured", configured, 0);
      tick();
      rst_n = 1'b1;
      PREADY = 1'b1;
      tx_valid = 1'b1;
      #1;
      check("post_rst_tx_blocked", tx_ready, 0);
      repeat (3) tick();
      check("post_rst_psel", PSEL, 0);
      tx_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
